// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the handshaked ALU (alu_hs_seq).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ILL0 = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MUL  = 3'b100,
        OP_SUB  = 3'b101,
        OP_SLT  = 3'b110,
        OP_ILL7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic op_is_addsub(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_hs_seq_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_hs_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic             out_z;
    logic             out_n;
    logic             out_c;
    logic             out_v;
    logic             out_err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_z, out_n, out_c, out_v, out_err
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_z, out_n, out_c, out_v, out_err
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps,
// low WIDTH bits of the product presented combinationally alongside done.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    // done marks the cycle whose step is the last; the caller captures acc_next at that edge
    assign done     = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg   <= 1'b0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (start) begin
            busy_reg   <= 1'b1;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_hs_seq.sv
// Registered handshaked ALU with Z/N/C/V/err flags. Define ALU_MUL_EN to build the
// iterative multiplier for opcode 100; otherwise that opcode reports an error.
module alu_hs_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SLT_SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    alu_hs_seq_if.slave  bus
);
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_state_e       state_reg, state_next;
    logic             in_ready, accept, mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] r_reg;
    logic             z_reg, n_reg, c_reg, v_reg, err_reg;

    logic             is_sub, slt_lt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_r;
    logic             res_c, res_v, res_err;

    assign in_ready  = !rst && ((state_reg == ST_IDLE) ||
                                ((state_reg == ST_DONE) && bus.out_ready));
    assign accept    = bus.in_valid && in_ready;
    assign mul_start = accept && MUL_EN && (bus.in_op == OP_MUL);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_reg == ST_DONE);
    assign bus.out_r     = r_reg;
    assign bus.out_z     = z_reg;
    assign bus.out_n     = n_reg;
    assign bus.out_c     = c_reg;
    assign bus.out_v     = v_reg;
    assign bus.out_err   = err_reg;

`ifdef ALU_MUL_EN
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.in_a),
        .b       (bus.in_b),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    generate
        if (SLT_SIGNED) begin : g_slt_signed
            assign slt_lt = $signed(bus.in_a) < $signed(bus.in_b);
        end else begin : g_slt_unsigned
            assign slt_lt = bus.in_a < bus.in_b;
        end
    endgenerate

    // SUB is A + ~B + 1, so the carry-out is the "no borrow" flag directly
    assign is_sub = (bus.in_op == OP_SUB);
    assign b_eff  = is_sub ? ~bus.in_b : bus.in_b;
    assign sum    = {1'b0, bus.in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

    always_comb begin
        res_r   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (alu_op_e'(bus.in_op))
            OP_ADD, OP_SUB: res_r = sum[WIDTH-1:0];
            OP_AND:         res_r = bus.in_a & bus.in_b;
            OP_OR:          res_r = bus.in_a | bus.in_b;
            OP_SLT:         res_r = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_MUL:         res_err = !MUL_EN;
            default:        res_err = 1'b1;
        endcase
        if (op_is_addsub(bus.in_op)) begin
            res_c = sum[WIDTH];
            res_v = (bus.in_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = mul_start ? ST_BUSY : ST_DONE;
            end
            ST_BUSY: begin
                if (mul_done) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    if (accept) state_next = mul_start ? ST_BUSY : ST_DONE;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg   <= '0;
            z_reg   <= 1'b0;
            n_reg   <= 1'b0;
            c_reg   <= 1'b0;
            v_reg   <= 1'b0;
            err_reg <= 1'b0;
        end else if (accept && !mul_start) begin
            r_reg   <= res_r;
            z_reg   <= (res_r == '0);
            n_reg   <= res_r[WIDTH-1];
            c_reg   <= res_c;
            v_reg   <= res_v;
            err_reg <= res_err;
        end else if ((state_reg == ST_BUSY) && mul_done) begin
            r_reg   <= mul_product;
            z_reg   <= (mul_product == '0);
            n_reg   <= mul_product[WIDTH-1];
            c_reg   <= 1'b0;
            v_reg   <= 1'b0;
            err_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_hs_seq.sv
// Directed-vector bench for alu_hs_seq: unsigned-SLT instance is driven, a signed-SLT
// twin shadows the same inputs so both SLT flavours are observed.
module tb_alu_hs_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_hs_seq_if #(.WIDTH(32)) bus ();
    alu_hs_seq_if #(.WIDTH(32)) bus_s ();

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.in_op     = bus.in_op;
    assign bus_s.in_a      = bus.in_a;
    assign bus_s.in_b      = bus.in_b;
    assign bus_s.out_ready = bus.out_ready;

    alu_hs_seq #(.WIDTH(32), .SLT_SIGNED(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_hs_seq #(.WIDTH(32), .SLT_SIGNED(1'b1)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] s_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // {z, n, c, v, err}
    function automatic logic [31:0] flags_of();
        return {27'b0, bus.out_z, bus.out_n, bus.out_c, bus.out_v, bus.out_err};
    endfunction

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r,
                         input logic [4:0] exp_f, input int exp_lat);
        int n;
        int lat;
        int rdy_bad;
        @(negedge clk);
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        rdy_bad = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (bus.in_ready) rdy_bad++;
        end
        s_r = bus_s.out_r;
        $display("op=%0d a=0x%08h b=0x%08h -> r=0x%08h zncve=%05b lat=%0d",
                 op, a, b, bus.out_r, flags_of(), lat);
        check({tag, "_r"}, bus.out_r, exp_r);
        check({tag, "_flags"}, flags_of(), {27'b0, exp_f});
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_rdy"}, rdy_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=0x00000000 exp=0x00000001");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] or_a[4];
        logic [31:0] exp_seq[5];
        int seen;
        or_a    = '{32'h1, 32'h2, 32'h4, 32'h8};
        exp_seq = '{32'h0000_00F0, 32'h0000_0101, 32'h0000_0102, 32'h0000_0104, 32'h0000_0108};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("post_rst_r", bus.out_r, 32'd0);
        check("post_rst_flags", flags_of(), 32'd0);
        check("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);

        do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10100, 1);
        do_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b00110, 1);
        do_op("sub_brw",  OP_SUB, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 5'b01000, 1);
        do_op("sub_eq",   OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 5'b10100, 1);
        do_op("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'b01010, 1);
        do_op("and",      OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 5'b00000, 1);
        do_op("or_zero",  OP_OR,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 5'b10000, 1);
        do_op("slt_a",    OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10000, 1);
        check("slt_a_signed", s_r, 32'd1);
        do_op("slt_b",    OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000, 1);
        check("slt_b_signed", s_r, 32'd0);
        do_op("ill7",     3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 5'b10001, 1);
        do_op("ill0",     3'b000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 5'b10001, 1);
`ifdef ALU_MUL_EN
        do_op("mul_7x6",  OP_MUL, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 5'b00000, 33);
        do_op("mul_m1sq", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000, 33);
        do_op("mul_wrap", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 5'b10000, 33);
`else
        do_op("mul_off",  OP_MUL, 32'h0000_0007, 32'h0000_0006, 32'h0000_0000, 5'b10001, 1);
`endif

        // back-pressure: AND result held while the next beat waits at the input
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_op     = OP_AND;
        bus.in_a      = 32'h0000_F0F0;
        bus.in_b      = 32'h0000_0FF0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_op = OP_OR;
        bus.in_a  = or_a[0];
        bus.in_b  = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_r", bus.out_r, 32'h0000_00F0);
            check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            $display("stream k=%0d valid=%0d r=0x%08h", k, bus.out_valid, bus.out_r);
            check("stream_valid", {31'b0, bus.out_valid}, 32'd1);
            check("stream_r", bus.out_r, exp_seq[k]);
            @(posedge clk);
            #1;
            if (k < 3) begin
                bus.in_a = or_a[k+1];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // reset in the middle of a multiply (or a held result when the multiplier is absent)
        bus.out_ready = 1'b0;
        bus.in_op     = OP_MUL;
        bus.in_a      = 32'h0000_0003;
        bus.in_b      = 32'h0000_0005;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        $display("reset mid-op: valid=%0d r=0x%08h ready=%0d", bus.out_valid, bus.out_r, bus.in_ready);
        check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_r", bus.out_r, 32'd0);
        check("midrst_flags", flags_of(), 32'd0);
        check("midrst_idle_ready", {31'b0, bus.in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midrst_no_stale", seen, 0);

        do_op("add_after_rst", OP_ADD, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 5'b00000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
